// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
// The master side is the requester/consumer population, the slave side is the arbiter.
interface alu_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ID_W   = 2,
   parameter int unsigned DATA_W = 32
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ-1:0]        req_ready;
   logic [6*N_REQ-1:0]      req_opcode;
   logic [DATA_W*N_REQ-1:0] req_x1;
   logic [DATA_W*N_REQ-1:0] req_x2;

   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   logic [DATA_W-1:0]       rsp_data;
   logic                    rsp_err;

   modport master (
      output req_valid, req_opcode, req_x1, req_x2, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_opcode, req_x1, req_x2, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
   );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
// One operation in flight at a time: IDLE (grant + latch) -> EXEC (ALU driven) -> RESP (hold
// response until accepted). Illegal opcodes never reach the ALU and answer with rsp_err.
module alu_arbiter #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ID_W   = 2,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   alu_arbiter_if.slave      bus,
   output logic              alu_en,
   output logic [5:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_x1,
   output logic [DATA_W-1:0] alu_x2,
   input  logic [DATA_W-1:0] alu_y,
   output logic              busy
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   localparam logic [5:0] OpAdd = 6'h04;
   localparam logic [5:0] OpXor = 6'h0A;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   id_q;
   logic [5:0]        op_q;
   logic [DATA_W-1:0] x1_q;
   logic [DATA_W-1:0] x2_q;
   logic              legal_q;
   logic [DATA_W-1:0] res_q;
   logic              err_q;

   logic              gnt_found;
   logic [ID_W-1:0]   gnt_id;
   logic [N_REQ-1:0]  gnt_onehot;
   logic              grant;
   logic              in_idle;
   logic              in_exec;
   logic              in_resp;
   logic              rsp_fire;
   logic              exec_legal;

   logic [5:0]        sel_op;
   logic [DATA_W-1:0] sel_x1;
   logic [DATA_W-1:0] sel_x2;

   // Legal opcodes form the contiguous range ADD..XOR.
   function automatic logic op_legal(input logic [5:0] op);
      return (op >= OpAdd) && (op <= OpXor);
   endfunction

   assign in_idle  = (state_q == StIdle);
   assign in_exec  = (state_q == StExec);
   assign in_resp  = (state_q == StResp);
   assign rsp_fire = in_resp && bus.rsp_ready;

   // Round-robin search: first valid requester starting at ptr+1, wrapping at N_REQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
         if (!gnt_found && bus.req_valid[(int'(ptr_q) + k) % int'(N_REQ)]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'((int'(ptr_q) + k) % int'(N_REQ));
         end
      end
   end

   // A grant happens only in IDLE and never while reset is asserted, so req_ready is 0 in reset.
   assign grant      = in_idle && gnt_found && !rst;
   assign gnt_onehot = grant ? (N_REQ'(1) << gnt_id) : '0;

   // Payload of the winning requester, captured on the grant cycle.
   always_comb begin
      sel_op = bus.req_opcode[6*gnt_id +: 6];
      sel_x1 = bus.req_x1[DATA_W*gnt_id +: DATA_W];
      sel_x2 = bus.req_x2[DATA_W*gnt_id +: DATA_W];
   end

   // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (gnt_found) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (bus.rsp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, round-robin pointer and operation registers; reset discards any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         ptr_q   <= ID_W'(N_REQ - 1);
         id_q    <= '0;
         op_q    <= '0;
         x1_q    <= '0;
         x2_q    <= '0;
         legal_q <= 1'b0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            id_q    <= gnt_id;
            op_q    <= sel_op;
            x1_q    <= sel_x1;
            x2_q    <= sel_x2;
            legal_q <= op_legal(sel_op);
         end
         if (in_exec) begin
            res_q <= legal_q ? alu_y : '0;
            err_q <= !legal_q;
         end
         if (rsp_fire) begin
            ptr_q <= id_q;
         end
      end
   end

   // ALU inputs are zero except during EXEC of a legal op, so it never sees an illegal opcode.
   assign exec_legal = in_exec && legal_q;

   // Drive the shared ALU from the latched operands only.
   always_comb begin
      alu_en     = exec_legal;
      alu_opcode = exec_legal ? op_q : 6'h00;
      alu_x1     = exec_legal ? x1_q : '0;
      alu_x2     = exec_legal ? x2_q : '0;
   end

   // Response channel decoded from the state; payload held stable through RESP.
   always_comb begin
      bus.req_ready = gnt_onehot;
      bus.rsp_valid = in_resp;
      bus.rsp_id    = in_resp ? id_q : '0;
      bus.rsp_data  = in_resp ? res_q : '0;
      bus.rsp_err   = in_resp ? err_q : 1'b0;
      busy          = !in_idle;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single-requester operations plus directed
// sequences for round-robin bursts, response back-pressure and reset during EXEC.
module tb_alu_arbiter;

   localparam int unsigned N_REQ  = 4;
   localparam int unsigned ID_W   = 2;
   localparam int unsigned DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              alu_en;
   logic [5:0]        alu_opcode;
   logic [31:0]       alu_x1;
   logic [31:0]       alu_x2;
   logic [31:0]       alu_y;
   logic              busy;

   int n_cmp;
   int n_bad;

   alu_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

   alu_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_en     (alu_en),
      .alu_opcode (alu_opcode),
      .alu_x1     (alu_x1),
      .alu_x2     (alu_x2),
      .alu_y      (alu_y),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: y = x2 op x1; garbage when disabled so a mistimed sample shows up.
   always_comb begin
      alu_y = 32'hDEAD_BEEF;
      if (alu_en) begin
         case (alu_opcode)
            6'h04:   alu_y = alu_x2 + alu_x1;
            6'h05:   alu_y = alu_x2 - alu_x1;
            6'h06:   alu_y = alu_x2 >> alu_x1[4:0];
            6'h07:   alu_y = alu_x2 << alu_x1[4:0];
            6'h08:   alu_y = alu_x2 & alu_x1;
            6'h09:   alu_y = alu_x2 | alu_x1;
            6'h0A:   alu_y = alu_x2 ^ alu_x1;
            default: alu_y = 32'hDEAD_BEEF;
         endcase
      end
   end

   typedef struct {
      int          req;
      logic [5:0]  op;
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_payload(input int r, input logic [5:0] op, input logic [31:0] x1,
                              input logic [31:0] x2);
      bus.req_opcode[6*r +: 6] = op;
      bus.req_x1[32*r +: 32]   = x1;
      bus.req_x2[32*r +: 32]   = x2;
   endtask

   // One isolated transaction from requester r with rsp_ready high; entered in an IDLE cycle.
   task automatic run_one(input int r, input logic [5:0] op, input logic [31:0] x1,
                          input logic [31:0] x2, input logic [31:0] exp_data,
                          input logic exp_err, input string tag);
      logic [3:0] onehot;
      onehot = 4'(1 << r);
      set_payload(r, op, x1, x2);
      bus.req_valid = onehot;
      #1;
      chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(onehot));
      chk({tag, " busy idle"}, 32'(busy), 32'd0);
      tick();
      bus.req_valid = '0;
      #1;
      chk({tag, " alu_en"}, 32'(alu_en), 32'(!exp_err));
      chk({tag, " alu_opcode"}, 32'(alu_opcode), exp_err ? 32'd0 : 32'(op));
      if (!exp_err) begin
         chk({tag, " alu_x1"}, alu_x1, x1);
         chk({tag, " alu_x2"}, alu_x2, x2);
      end
      chk({tag, " rsp_valid exec"}, 32'(bus.rsp_valid), 32'd0);
      tick();
      chk({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(r));
      chk({tag, " rsp_data"}, bus.rsp_data, exp_data);
      chk({tag, " rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
      chk({tag, " alu_en resp"}, 32'(alu_en), 32'd0);
      tick();
      chk({tag, " back idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;

      vecs[0] = '{req: 0, op: 6'h04, x1: 32'd5,         x2: 32'd7,         exp_data: 32'd12,        exp_err: 1'b0};
      vecs[1] = '{req: 3, op: 6'h07, x1: 32'd31,        x2: 32'd1,         exp_data: 32'h8000_0000, exp_err: 1'b0};
      vecs[2] = '{req: 1, op: 6'h0A, x1: 32'h0F0F_0F0F, x2: 32'hFFFF_0000, exp_data: 32'hF0F0_0F0F, exp_err: 1'b0};
      vecs[3] = '{req: 2, op: 6'h3F, x1: 32'd1,         x2: 32'd2,         exp_data: 32'd0,         exp_err: 1'b1};
      vecs[4] = '{req: 0, op: 6'h05, x1: 32'd3,         x2: 32'd10,        exp_data: 32'd7,         exp_err: 1'b0};
      vecs[5] = '{req: 1, op: 6'h06, x1: 32'd4,         x2: 32'h80,        exp_data: 32'h8,         exp_err: 1'b0};
      vecs[6] = '{req: 2, op: 6'h08, x1: 32'hF0F0,      x2: 32'hFF00,      exp_data: 32'hF000,      exp_err: 1'b0};
      vecs[7] = '{req: 3, op: 6'h09, x1: 32'h0F,        x2: 32'hF0,        exp_data: 32'hFF,        exp_err: 1'b0};
      vecs[8] = '{req: 0, op: 6'h03, x1: 32'd9,         x2: 32'd9,         exp_data: 32'd0,         exp_err: 1'b1};
      vecs[9] = '{req: 1, op: 6'h0B, x1: 32'd9,         x2: 32'd9,         exp_data: 32'd0,         exp_err: 1'b1};

      rst            = 1'b1;
      bus.req_valid  = '0;
      bus.req_opcode = '0;
      bus.req_x1     = '0;
      bus.req_x2     = '0;
      bus.rsp_ready  = 1'b1;
      tick();
      tick();

      // Reset values, with a request present to prove req_ready stays low under reset.
      bus.req_valid = 4'b0001;
      #1;
      chk("reset req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("reset alu_en", 32'(alu_en), 32'd0);
      chk("reset alu_opcode", 32'(alu_opcode), 32'd0);
      bus.req_valid = '0;
      tick();
      rst = 1'b0;

      // Two bursts of four simultaneous SUB requests: order 0,1,2,3 each time.
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 4; i++) set_payload(i, 6'h05, 32'(i), 32'd10);
         bus.req_valid = 4'b1111;
         for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("burst%0d grant%0d", b, k), 32'(bus.req_ready), 32'(1 << k));
            tick();
            bus.req_valid[k] = 1'b0;
            #1;
            chk($sformatf("burst%0d exec req_ready%0d", b, k), 32'(bus.req_ready), 32'd0);
            tick();
            chk($sformatf("burst%0d rsp_id%0d", b, k), 32'(bus.rsp_id), 32'(k));
            chk($sformatf("burst%0d rsp_data%0d", b, k), bus.rsp_data, 32'(10 - k));
            tick();
         end
      end

      // Table of isolated operations.
      for (int v = 0; v < 10; v++) begin
         run_one(vecs[v].req, vecs[v].op, vecs[v].x1, vecs[v].x2, vecs[v].exp_data,
                 vecs[v].exp_err, $sformatf("vec%0d", v));
      end

      // Back-pressure: response held 5 cycles with req1 pending, req1 granted right after.
      bus.rsp_ready = 1'b0;
      set_payload(0, 6'h04, 32'd5, 32'd7);
      bus.req_valid = 4'b0001;
      #1;
      chk("stall grant0", 32'(bus.req_ready), 32'd1);
      tick();
      set_payload(1, 6'h09, 32'd1, 32'd2);
      bus.req_valid = 4'b0010;
      #1;
      chk("stall exec req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("stall%0d rsp_valid", c), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("stall%0d rsp_data", c), bus.rsp_data, 32'd12);
         chk($sformatf("stall%0d rsp_id", c), 32'(bus.rsp_id), 32'd0);
         chk($sformatf("stall%0d req_ready", c), 32'(bus.req_ready), 32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("stall release rsp_valid", 32'(bus.rsp_valid), 32'd1);
      tick();
      chk("stall next grant1", 32'(bus.req_ready), 32'd2);
      tick();
      bus.req_valid = '0;
      tick();
      chk("stall req1 rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("stall req1 rsp_data", bus.rsp_data, 32'd3);
      tick();

      // Reset during EXEC: op discarded, pointer back so the lowest valid index wins.
      set_payload(2, 6'h04, 32'd1, 32'd1);
      bus.req_valid = 4'b0100;
      #1;
      chk("rstexec grant2", 32'(bus.req_ready), 32'd4);
      tick();
      rst = 1'b1;
      set_payload(1, 6'h04, 32'd2, 32'd3);
      set_payload(3, 6'h04, 32'd8, 32'd8);
      bus.req_valid = 4'b1010;
      #1;
      chk("rstexec alu_en", 32'(alu_en), 32'd1);
      tick();
      chk("rstexec busy", 32'(busy), 32'd0);
      chk("rstexec rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rstexec req_ready", 32'(bus.req_ready), 32'd0);
      chk("rstexec alu_en after", 32'(alu_en), 32'd0);
      chk("rstexec rsp_err", 32'(bus.rsp_err), 32'd0);
      rst = 1'b0;
      #1;
      chk("rstexec first grant", 32'(bus.req_ready), 32'd2);
      tick();
      bus.req_valid = 4'b1000;
      tick();
      chk("rstexec rsp_id", 32'(bus.rsp_id), 32'd1);
      chk("rstexec rsp_data", bus.rsp_data, 32'd5);
      bus.req_valid = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
